// File: rtl/otsu_pkg.sv
// Shared definitions for the Otsu class-statistics datapath.
//   - default widths for bin index, per-bin count and accumulators
//   - FSM state encoding for otsu_class_stats
//   - class-select encoding (background / foreground)
package otsu_pkg;

   localparam int BIN_W_DEF = 8;
   localparam int CNT_W_DEF = 32;
   localparam int ACC_W_DEF = 48;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Background is bin <= T, foreground is bin > T.
   typedef enum logic {
      CLS_FG = 1'b0,
      CLS_BG = 1'b1
   } cls_t;

endpackage

// File: rtl/otsu_sat_acc.sv
// Saturating adder for one class accumulator.
//   acc    : current accumulator value
//   addend : zero-extended term to add
//   sum    : acc + addend, clamped to all-ones on carry-out
//   ovf    : carry-out of the ACC_W-bit addition occurred
module otsu_sat_acc #(
   parameter int ACC_W = 48
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W:0] full;

   assign full = {1'b0, acc} + {1'b0, addend};
   assign ovf  = full[ACC_W];
   assign sum  = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/otsu_class_stats.sv
// Single-pass background/foreground statistics for one threshold T.
// Consumes (bin, count) beats of a histogram pass and produces
//   w_bg/w_fg     : sum of counts per class
//   sum_bg/sum_fg : sum of bin*count per class
//   ovf           : some accumulator saturated during this pass
// Ports:
//   clk, reset (async, active low)
//   start, threshold         : pass launch, T latched in IDLE
//   in_valid/in_ready, in_bin, in_count, in_last : beat stream
//   out_valid/out_ready      : result handshake (held in DONE)
//   busy                     : state != IDLE
// Pipeline: stage 1 registers product/count/class; stage 2 is the
// accumulator update, so a beat lands one cycle after acceptance.
module otsu_class_stats
   import otsu_pkg::*;
#(
   parameter int BIN_W = BIN_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] threshold,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_bin,
   input  logic [CNT_W-1:0] in_count,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] w_bg,
   output logic [ACC_W-1:0] w_fg,
   output logic [ACC_W-1:0] sum_bg,
   output logic [ACC_W-1:0] sum_fg,
   output logic             ovf,
   output logic             busy
);

   localparam int P_W = BIN_W + CNT_W;

   generate
      if (ACC_W < P_W) begin : g_bad_acc_w
         $error("otsu_class_stats: ACC_W must be >= BIN_W+CNT_W");
      end
   endgenerate

   typedef struct packed {
      logic [P_W-1:0]   p;
      logic [CNT_W-1:0] cnt;
      cls_t             cls;
      logic             last;
   } s1_t;

   state_t           state, state_nxt;
   logic [BIN_W-1:0] thr_q;
   logic             s1_vld;
   s1_t              s1;
   logic             beat_acc;
   logic             start_acc;
   logic [P_W-1:0]   prod;

   logic [ACC_W-1:0] w_bg_nxt, w_fg_nxt, sum_bg_nxt, sum_fg_nxt;
   logic             ov_wbg, ov_wfg, ov_sbg, ov_sfg;
   logic [ACC_W-1:0] cnt_ext, p_ext;

   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign beat_acc  = in_valid & in_ready;
   assign start_acc = (state == ST_IDLE) & start;
   assign prod      = P_W'(in_bin) * P_W'(in_count);

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_ACCUM;
         ST_ACCUM: if (beat_acc && in_last) state_nxt = ST_DRAIN;
         // Stage 1 holds the last beat here; it retires this cycle.
         ST_DRAIN: if (s1_vld && s1.last) state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Threshold latch and stage 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thr_q  <= '0;
         s1_vld <= 1'b0;
         s1     <= '0;
      end else begin
         if (start_acc) thr_q <= threshold;
         s1_vld <= beat_acc;
         if (beat_acc) begin
            s1.p    <= prod;
            s1.cnt  <= in_count;
            s1.cls  <= (in_bin <= thr_q) ? CLS_BG : CLS_FG;
            s1.last <= in_last;
         end
      end
   end

   // Stage 2: saturating adds, only the selected class is written back
   assign cnt_ext = ACC_W'(s1.cnt);
   assign p_ext   = ACC_W'(s1.p);

   otsu_sat_acc #(.ACC_W(ACC_W)) u_acc_wbg (.acc(w_bg),   .addend(cnt_ext), .sum(w_bg_nxt),   .ovf(ov_wbg));
   otsu_sat_acc #(.ACC_W(ACC_W)) u_acc_wfg (.acc(w_fg),   .addend(cnt_ext), .sum(w_fg_nxt),   .ovf(ov_wfg));
   otsu_sat_acc #(.ACC_W(ACC_W)) u_acc_sbg (.acc(sum_bg), .addend(p_ext),   .sum(sum_bg_nxt), .ovf(ov_sbg));
   otsu_sat_acc #(.ACC_W(ACC_W)) u_acc_sfg (.acc(sum_fg), .addend(p_ext),   .sum(sum_fg_nxt), .ovf(ov_sfg));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_bg   <= '0;
         w_fg   <= '0;
         sum_bg <= '0;
         sum_fg <= '0;
         ovf    <= 1'b0;
      end else if (start_acc) begin
         w_bg   <= '0;
         w_fg   <= '0;
         sum_bg <= '0;
         sum_fg <= '0;
         ovf    <= 1'b0;
      end else if (s1_vld) begin
         if (s1.cls == CLS_BG) begin
            w_bg   <= w_bg_nxt;
            sum_bg <= sum_bg_nxt;
            ovf    <= ovf | ov_wbg | ov_sbg;
         end else begin
            w_fg   <= w_fg_nxt;
            sum_fg <= sum_fg_nxt;
            ovf    <= ovf | ov_wfg | ov_sfg;
         end
      end
   end

endmodule

// File: tb/tb_otsu_class_stats.sv
// Self-checking bench for otsu_class_stats: directed scenarios plus
// randomized passes compared against a plain-arithmetic class model.
module tb_otsu_class_stats;

   localparam int BIN_W = 8;
   localparam int CNT_W = 32;
   localparam int ACC_W = 40;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [BIN_W-1:0] threshold = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BIN_W-1:0] in_bin = '0;
   logic [CNT_W-1:0] in_count = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] w_bg, w_fg, sum_bg, sum_fg;
   logic             ovf;
   logic             busy;

   otsu_class_stats #(.BIN_W(BIN_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .start(start), .threshold(threshold),
      .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
      .in_count(in_count), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .w_bg(w_bg), .w_fg(w_fg), .sum_bg(sum_bg),
      .sum_fg(sum_fg), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [BIN_W-1:0] q_bin[$];
   logic [CNT_W-1:0] q_cnt[$];

   logic [ACC_W-1:0] e_wbg, e_wfg, e_sbg, e_sfg;
   logic             e_ovf;

   // pass-level observations from run_pass
   bit tmo, rdy1, drain_ov, done_ov;
   int acc_cycles;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_beat(input logic [BIN_W-1:0] b, input logic [CNT_W-1:0] c);
      q_bin.push_back(b);
      q_cnt.push_back(c);
   endtask

   // Class statistics straight from the definition; saturation is a clamp
   // of the exact total because every term is non-negative.
   task automatic model(input logic [BIN_W-1:0] thr);
      logic [127:0] t_wbg, t_wfg, t_sbg, t_sfg, mx, p;
      t_wbg = 0; t_wfg = 0; t_sbg = 0; t_sfg = 0;
      mx = (128'd1 << ACC_W) - 128'd1;
      for (int i = 0; i < q_bin.size(); i++) begin
         p = 128'(q_bin[i]) * 128'(q_cnt[i]);
         if (q_bin[i] <= thr) begin
            t_wbg += 128'(q_cnt[i]);
            t_sbg += p;
         end else begin
            t_wfg += 128'(q_cnt[i]);
            t_sfg += p;
         end
      end
      e_ovf = (t_wbg > mx) || (t_wfg > mx) || (t_sbg > mx) || (t_sfg > mx);
      e_wbg = (t_wbg > mx) ? mx[ACC_W-1:0] : t_wbg[ACC_W-1:0];
      e_wfg = (t_wfg > mx) ? mx[ACC_W-1:0] : t_wfg[ACC_W-1:0];
      e_sbg = (t_sbg > mx) ? mx[ACC_W-1:0] : t_sbg[ACC_W-1:0];
      e_sfg = (t_sfg > mx) ? mx[ACC_W-1:0] : t_sfg[ACC_W-1:0];
   endtask

   // Drive one pass from the queues; leaves the DUT in DONE (not handshaken).
   task automatic run_pass(input logic [BIN_W-1:0] thr, input int max_gap);
      int n;
      tmo = 0; acc_cycles = 0;
      n = 0;
      while (busy && n < 50) begin step(); n++; end
      if (busy) tmo = 1;
      start = 1'b1; threshold = thr;
      step();
      start = 1'b0;
      rdy1 = in_ready;
      for (int i = 0; i < q_bin.size(); i++) begin
         if (max_gap > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, max_gap)) step();
         end
         in_valid = 1'b1; in_bin = q_bin[i]; in_count = q_cnt[i];
         in_last  = (i == q_bin.size() - 1);
         n = 0;
         while (!in_ready && n < 20) begin step(); n++; acc_cycles++; end
         if (!in_ready) tmo = 1;
         step();
         acc_cycles++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      drain_ov = out_valid;
      step();
      done_ov = out_valid;
   endtask

   task automatic finish_pass();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) step();
      n_chk++;
      if ({out_valid, in_ready, busy, ovf} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {out_valid, in_ready, busy, ovf});
      end
      n_chk++;
      if ({w_bg, w_fg, sum_bg, sum_fg} !== '0) begin
         n_fail++; $display("FAIL reset_acc: got %h %h %h %h exp all 0", w_bg, w_fg, sum_bg, sum_fg);
      end
      reset = 1'b1;
      step();
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy got %b exp 0", busy); end
   endtask

   task automatic test_basic();
      q_bin.delete(); q_cnt.delete();
      add_beat(0, 5); add_beat(1, 3); add_beat(2, 4); add_beat(3, 2); add_beat(4, 1);
      run_pass(2, 0);
      n_chk++;
      if (tmo) begin n_fail++; $display("FAIL basic_timeout: handshake stalled"); end
      n_chk++;
      if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_start: got %b exp 1", rdy1); end
      n_chk++;
      if ({drain_ov, done_ov} !== 2'b01) begin
         n_fail++; $display("FAIL basic_latency: out_valid t+1/t+2 got %b exp 01", {drain_ov, done_ov});
      end
      n_chk++;
      if (w_bg !== 40'd12 || sum_bg !== 40'd11) begin
         n_fail++; $display("FAIL basic_bg: got w=%0d s=%0d exp w=12 s=11", w_bg, sum_bg);
      end
      n_chk++;
      if (w_fg !== 40'd3 || sum_fg !== 40'd10 || ovf !== 1'b0) begin
         n_fail++; $display("FAIL basic_fg: got w=%0d s=%0d ovf=%b exp w=3 s=10 ovf=0", w_fg, sum_fg, ovf);
      end
      finish_pass();
      n_chk++;
      if ({out_valid, busy} !== 2'b00) begin
         n_fail++; $display("FAIL basic_handshake: out_valid,busy got %b exp 00", {out_valid, busy});
      end
   endtask

   task automatic test_back_to_back();
      q_bin.delete(); q_cnt.delete();
      for (int i = 0; i < 256; i++) add_beat(i[BIN_W-1:0], 1);
      run_pass(8'd255, 0);
      n_chk++;
      if (tmo || acc_cycles != 256) begin
         n_fail++; $display("FAIL b2b_throughput: got %0d cycles tmo=%b exp 256", acc_cycles, tmo);
      end
      n_chk++;
      if (w_bg !== 40'd256 || sum_bg !== 40'd32640 || w_fg !== 40'd0 || sum_fg !== 40'd0) begin
         n_fail++; $display("FAIL b2b_values: got %0d %0d %0d %0d exp 256 32640 0 0", w_bg, sum_bg, w_fg, sum_fg);
      end
      finish_pass();
   endtask

   task automatic test_saturation();
      q_bin.delete(); q_cnt.delete();
      add_beat(8'd255, 32'hFFFF_FFFF); add_beat(8'd255, 32'hFFFF_FFFF);
      run_pass(8'd255, 0);
      n_chk++;
      if (sum_bg !== 40'hFF_FFFF_FFFF || ovf !== 1'b1) begin
         n_fail++; $display("FAIL sat_sum: got %h ovf=%b exp ffffffffff ovf=1", sum_bg, ovf);
      end
      n_chk++;
      if (w_bg !== 40'h1_FFFF_FFFE) begin
         n_fail++; $display("FAIL sat_weight: got %h exp 1fffffffe", w_bg);
      end
      finish_pass();
      q_bin.delete(); q_cnt.delete();
      add_beat(8'd0, 32'd7);
      run_pass(8'd0, 0);
      n_chk++;
      if (ovf !== 1'b0 || w_bg !== 40'd7 || sum_bg !== 40'd0) begin
         n_fail++; $display("FAIL sat_clear: got ovf=%b w=%0d s=%0d exp 0 7 0", ovf, w_bg, sum_bg);
      end
      finish_pass();
   endtask

   task automatic test_hold();
      q_bin.delete(); q_cnt.delete();
      for (int i = 0; i < 6; i++) add_beat($urandom_range(0, 255), $urandom_range(0, 1000));
      model(8'd128);
      run_pass(8'd128, 0);
      for (int c = 0; c < 10; c++) begin
         start = c[0];
         threshold = $urandom_range(0, 255);
         step();
         n_chk++;
         if (out_valid !== 1'b1 || {w_bg, w_fg, sum_bg, sum_fg, ovf} !== {e_wbg, e_wfg, e_sbg, e_sfg, e_ovf}) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got v=%b %h %h %h %h %b exp v=1 %h %h %h %h %b", c, out_valid,
                     w_bg, w_fg, sum_bg, sum_fg, ovf, e_wbg, e_wfg, e_sbg, e_sfg, e_ovf);
         end
      end
      start = 1'b0;
      finish_pass();
      n_chk++;
      if ({out_valid, busy, in_ready} !== 3'b000 || {w_bg, w_fg, sum_bg, sum_fg} !== {e_wbg, e_wfg, e_sbg, e_sfg}) begin
         n_fail++; $display("FAIL hold_release: got v/busy/rdy=%b w_bg=%h exp 000 w_bg=%h",
                            {out_valid, busy, in_ready}, w_bg, e_wbg);
      end
      step();
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_start_ignored: busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_midpass();
      start = 1'b1; threshold = 8'd100;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_bin = 8'(i * 60); in_count = 32'd9; in_last = 1'b0;
         step();
      end
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      n_chk++;
      if ({out_valid, busy, ovf, in_ready} !== 4'b0 || {w_bg, w_fg, sum_bg, sum_fg} !== '0) begin
         n_fail++; $display("FAIL midreset_clear: got ctrl=%b w_bg=%h w_fg=%h exp 0",
                            {out_valid, busy, ovf, in_ready}, w_bg, w_fg);
      end
      step();
      reset = 1'b1;
      step();
      q_bin.delete(); q_cnt.delete();
      for (int i = 0; i < 5; i++) add_beat($urandom_range(0, 255), $urandom_range(1, 50));
      model(8'd100);
      run_pass(8'd100, 1);
      n_chk++;
      if (tmo || {w_bg, w_fg, sum_bg, sum_fg, ovf} !== {e_wbg, e_wfg, e_sbg, e_sfg, e_ovf}) begin
         n_fail++; $display("FAIL midreset_newpass: got %h %h %h %h %b exp %h %h %h %h %b",
                            w_bg, w_fg, sum_bg, sum_fg, ovf, e_wbg, e_wfg, e_sbg, e_sfg, e_ovf);
      end
      finish_pass();
   endtask

   task automatic test_dup_gaps();
      q_bin.delete(); q_cnt.delete();
      add_beat(8'd3, 32'd2); add_beat(8'd3, 32'd2);
      run_pass(8'd3, 3);
      n_chk++;
      if (tmo || w_bg !== 40'd4 || sum_bg !== 40'd12 || w_fg !== 40'd0 || sum_fg !== 40'd0) begin
         n_fail++; $display("FAIL dup_gaps: got %0d %0d %0d %0d exp 4 12 0 0", w_bg, sum_bg, w_fg, sum_fg);
      end
      finish_pass();
   endtask

   task automatic test_random();
      logic [BIN_W-1:0] thr;
      for (int p = 0; p < 8; p++) begin
         q_bin.delete(); q_cnt.delete();
         thr = (p == 0) ? 8'd255 : 8'($urandom_range(0, 255));
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
            case ($urandom_range(0, 3))
               0:       add_beat($urandom_range(0, 255), 32'd0);
               1:       add_beat($urandom_range(0, 255), $urandom());
               default: add_beat($urandom_range(0, 255), $urandom_range(0, 5000));
            endcase
         end
         model(thr);
         run_pass(thr, (p % 2) * 2);
         n_chk++;
         if (tmo || done_ov !== 1'b1 || {w_bg, w_fg, sum_bg, sum_fg, ovf} !== {e_wbg, e_wfg, e_sbg, e_sfg, e_ovf}) begin
            n_fail++; $display("FAIL random_pass%0d: got v=%b %h %h %h %h %b exp %h %h %h %h %b", p, done_ov,
                               w_bg, w_fg, sum_bg, sum_fg, ovf, e_wbg, e_wfg, e_sbg, e_sfg, e_ovf);
         end
         finish_pass();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_saturation();
      test_hold();
      test_reset_midpass();
      test_dup_gaps();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
